// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding, step math.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of clock steps needed to walk all WIDTH bits, CHUNK at a time.
  function automatic int calc_nsteps(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Ceiling log2; returns the bit count needed to hold values 0..n-1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// CHUNK-bit ripple-carry adder slice built from full-adder bit cells.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b (CHUNK-bit operands), ci (carry in) -> s (CHUNK-bit sum), co (carry out).
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: {C,S} = A + B + cin, CHUNK bits per clock, LSB chunk first.
// Latency: start accepted at edge k -> done high in the cycle after edge k+NSTEPS.
// Backpressure: start is ignored while busy; a new start is accepted in IDLE or the done cycle.
// Ports: clk, rst_n (async active-low), start, A, B, cin in; busy, done, S, C out.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int NSTEPS = calc_nsteps(WIDTH, CHUNK);
  localparam int STEP_W = clog2(NSTEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              carry_q, carry_d;
  logic              c_q, c_d;
  logic [STEP_W-1:0] step_q, step_d;

  logic [CHUNK-1:0]       chunk_s;
  logic                   chunk_co;
  // New chunk lands above the current sum; taking the top WIDTH bits is a
  // right shift that also works when CHUNK == WIDTH.
  logic [WIDTH+CHUNK-1:0] sum_shift;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a  (a_q[CHUNK-1:0]),
    .b  (b_q[CHUNK-1:0]),
    .ci (carry_q),
    .s  (chunk_s),
    .co (chunk_co)
  );

  assign sum_shift = {chunk_s, sum_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_d     = c_q;
    step_d  = step_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done    = (state_q == ST_DONE);
        state_d = ST_IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = cin;
          sum_d   = '0;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = sum_shift[WIDTH+CHUNK-1:CHUNK];
        carry_d = chunk_co;
        step_d  = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          s_d     = sum_shift[WIDTH+CHUNK-1:CHUNK];
          c_d     = chunk_co;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      step_q  <= step_d;
    end
  end

  assign S = s_q;
  assign C = c_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;

  logic clk;
  logic rst_n;

  // 8-bit / 2-bit-chunk instance
  logic       start8, cin8, busy8, done8, c8;
  logic [7:0] a8, b8, s8;

  // Two 16-bit instances (full-width chunk and 1-bit chunk) share inputs
  logic        start16, cin16;
  logic [15:0] a16, b16;
  logic        busy_f, done_f, c_f;
  logic [15:0] s_f;
  logic        busy_s, done_s, c_s;
  logic [15:0] s_s;

  int vecs;
  int miscomp;

  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .cin(cin8),
    .busy(busy8), .done(done8), .S(s8), .C(c8)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16f (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16), .cin(cin16),
    .busy(busy_f), .done(done_f), .S(s_f), .C(c_f)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_dut16s (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16), .cin(cin16),
    .busy(busy_s), .done(done_s), .S(s_s), .C(c_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered on the first negedge after acceptance; returns cycles until done
  // and how many of those cycles showed busy.
  task automatic wait8(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!done8 && n < 40) begin
      if (busy8) nb++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [7:0] es, input logic ec);
    int n, nb;
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(n, nb);
    chk({name, "_lat"},  32'(n), 32'd4);
    chk({name, "_busy"}, 32'(nb), 32'd4);
    chk({name, "_S"},    32'(s8), 32'(es));
    chk({name, "_C"},    32'(c8), 32'(ec));
    @(negedge clk);
    chk({name, "_pulse"}, 32'(done8), 32'd0);
    chk({name, "_hold"},  32'(s8), 32'(es));
  endtask

  initial begin
    int n, nb, lf, ls, dcnt;
    logic [16:0] rf, rs, exp17;

    vecs = 0; miscomp = 0;
    tbl[0] = '{"zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{"ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{"a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{"12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl[4] = '{"80_80", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    tbl[5] = '{"7f_00", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_S",    32'(s8),    32'd0);
    chk("rst_C",    32'(c8),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run8(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].c);

    // Back-to-back: second start presented in the done cycle
    a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(n, nb);
    chk("b2b1_S", 32'(s8), 32'h00);
    chk("b2b1_C", 32'(c8), 32'd1);
    a8 = 8'h3C; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_accept", 32'(busy8), 32'd1);
    wait8(n, nb);
    chk("b2b2_lat", 32'(n), 32'd4);
    chk("b2b2_S", 32'(s8), 32'h4D);
    chk("b2b2_C", 32'(c8), 32'd0);
    @(negedge clk);

    // start while busy is ignored; input changes mid-run have no effect
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b0;
    wait8(n, nb);
    chk("ign_lat", 32'(n), 32'd3);
    chk("ign_S", 32'(s8), 32'h30);
    chk("ign_C", 32'(c8), 32'd0);
    @(negedge clk);
    chk("ign_idle", 32'(busy8), 32'd0);
    chk("ign_pulse", 32'(done8), 32'd0);

    // Reset in the middle of an operation
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy8), 32'd0);
    chk("mrst_done", 32'(done8), 32'd0);
    chk("mrst_S",    32'(s8),    32'd0);
    chk("mrst_C",    32'(c8),    32'd0);
    dcnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (done8) dcnt++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done8 || busy8) dcnt++;
    end
    chk("mrst_no_done", 32'(dcnt), 32'd0);
    run8("after_rst", 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0);

    // Random vectors on the 16-bit full-chunk and bit-serial instances
    for (int v = 0; v < 1000; v++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      cin16 = 1'($urandom_range(1, 0));
      exp17 = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      n = 0; lf = -1; ls = -1; rf = '0; rs = '0;
      while (n < 40 && (lf < 0 || ls < 0)) begin
        if (done_f && lf < 0) begin lf = n; rf = {c_f, s_f}; end
        if (done_s && ls < 0) begin ls = n; rs = {c_s, s_s}; end
        if (lf < 0 || ls < 0) begin
          n++;
          @(negedge clk);
        end
      end
      chk("rnd_w16c16_lat", 32'(lf), 32'd1);
      chk("rnd_w16c16_sum", 32'(rf), 32'(exp17));
      chk("rnd_w16c1_lat",  32'(ls), 32'd16);
      chk("rnd_w16c1_sum",  32'(rs), 32'(exp17));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
    $finish;
  end

endmodule
